owt_rx_frame: RTL and testbench
===============================

OWT_RX_FRAME -- requirements
Module: owt_rx_frame

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the payload bits per frame (range 1..32).
REQ-002 The block SHALL have parameter HEAD_W, default 4, giving the header length in bits.
REQ-003 The block SHALL have parameter HEAD, default 4'b1010, giving the header pattern, sent MSB first.
REQ-004 The block SHALL have parameter TO_W, default 10, giving the timeout counter width.
REQ-005 The block SHALL have parameter TO_TH, default TO_W'(512), giving the idle-cycle timeout threshold (must be >= 1).
REQ-006 The block SHALL have port i_clk, input, width 1: the single clock, rising edge.
REQ-007 The block SHALL have port i_rst_n, input, width 1: asynchronous, active-low reset.
REQ-008 The block SHALL have port i_bit_vld, input, width 1: a one-cycle strobe marking a detected OWT bit from the upstream bit detector.
REQ-009 The block SHALL have port i_bit_data, input, width 1: the bit value, sampled only when i_bit_vld=1.
REQ-010 The block SHALL have port o_frm_vld, output, width 1: a one-cycle pulse marking a good frame.
REQ-011 The block SHALL have port o_frm_data, output, width DATA_W: the payload of the last good frame.
REQ-012 The block SHALL have port o_par_err, output, width 1: a one-cycle pulse on a parity mismatch.
REQ-013 The block SHALL have port o_timeout, output, width 1: a one-cycle pulse when a frame is abandoned.
REQ-014 The block SHALL have port o_busy, output, width 1: high whenever the FSM is not in IDLE.

Function
REQ-015 Frame format SHALL be HEAD_W header bits, then DATA_W payload bits MSB first, then 1 parity bit equal to the XOR of the payload (even parity).
REQ-016 The FSM SHALL have states IDLE, HEAD, DATA and PAR, and SHALL advance only on cycles with i_bit_vld=1, except for timeout.
REQ-017 In IDLE, a bit equal to HEAD[HEAD_W-1] SHALL move the FSM to HEAD with index 1 (or to DATA if HEAD_W=1); any other bit SHALL leave it in IDLE.
REQ-018 In HEAD, a bit equal to HEAD[HEAD_W-1-idx] SHALL increment idx; when the last header bit matches, the FSM SHALL move to DATA with the bit count cleared.
REQ-019 On a header mismatch in HEAD, the FSM SHALL go to HEAD with idx=1 if the bit equals HEAD[HEAD_W-1], and to IDLE otherwise; no output is raised.
REQ-020 In DATA, each bit SHALL shift into the LSB of a DATA_W shift register; after DATA_W bits the FSM SHALL move to PAR.
REQ-021 In PAR, a bit equal to the XOR of the shift register SHALL cause o_frm_vld=1 and load o_frm_data on the next cycle; otherwise o_par_err=1 on the next cycle. In both cases the FSM SHALL return to IDLE.
REQ-022 Output latency SHALL be exactly 1 cycle from the parity i_bit_vld to o_frm_vld or o_par_err.
REQ-023 o_frm_data SHALL hold its value until the next good frame; a parity error or timeout SHALL NOT change it.
REQ-024 The timeout counter SHALL clear on every i_bit_vld and in IDLE, and SHALL otherwise increment while not in IDLE, saturating at TO_TH.
REQ-025 When the counter reaches TO_TH outside IDLE, the FSM SHALL return to IDLE and o_timeout SHALL pulse on the next cycle, once per abandoned frame.
REQ-026 If i_bit_vld=1 in the same cycle the counter reaches TO_TH, the bit SHALL be processed and the timeout SHALL be suppressed.
REQ-027 o_frm_vld, o_par_err and o_timeout SHALL be mutually exclusive and SHALL all be registered outputs.
REQ-028 i_bit_data SHALL be ignored when i_bit_vld=0.

Reset
REQ-029 While i_rst_n=0, the block SHALL hold FSM=IDLE, idx=0, bit count=0, shift register=0, timeout counter=0, and o_frm_vld=0, o_frm_data=0, o_par_err=0, o_timeout=0, o_busy=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no output pulse; the first bit after release SHALL be treated as arriving in IDLE.

Verification (DATA_W=16, HEAD=4'b1010, TO_TH=512)
REQ-031 Bits 1010, payload 16'hA5C3, parity 0 -> o_frm_vld=1 for 1 cycle, one cycle after the parity strobe, with o_frm_data=16'hA5C3.
REQ-032 Same frame with parity 1 -> o_par_err=1 for 1 cycle, o_frm_vld=0, and o_frm_data unchanged.
REQ-033 Bits 1,0,1,1,0,1,0 then payload 16'h0001 and parity 1 -> header resynchronises at the second 1 (idx=1) and o_frm_data=16'h0001 is reported.
REQ-034 Header plus 5 payload bits, then no i_bit_vld for 512 cycles -> o_timeout=1 for one cycle and o_busy falls; a following good frame is received normally.
REQ-035 i_bit_vld in the exact cycle the counter reaches 512 -> no o_timeout, and the bit is accepted.
REQ-036 Reset pulsed after 10 payload bits -> all outputs are 0, no pulse is raised, and a complete frame after release decodes correctly.

Source files
------------

// File: rtl/owt_rx_frame.sv
// rtl/owt_rx_frame.sv - OWT frame receiver: header hunt, payload shift, even parity, idle timeout
// Consumes one-cycle bit strobes and reports good frames, parity errors and abandoned frames.
module owt_rx_frame #(
  parameter int                DATA_W = 16,
  parameter int                HEAD_W = 4,
  parameter logic [HEAD_W-1:0] HEAD   = 4'b1010,
  parameter int                TO_W   = 10,
  parameter logic [TO_W-1:0]   TO_TH  = TO_W'(512)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bit_vld,
  input  logic              i_bit_data,
  output logic              o_frm_vld,
  output logic [DATA_W-1:0] o_frm_data,
  output logic              o_par_err,
  output logic              o_timeout,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = $clog2(HEAD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_DATA, S_PAR} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [DATA_W-1:0]   frm_data_q, frm_data_d;
  logic                frm_vld_q, frm_vld_d;
  logic                par_err_q, par_err_d;
  logic                timeout_q, timeout_d;

  logic [HEAD_W-1:0]   head_sh;
  logic                head_exp;
  logic                head_first;
  logic                idx_last;
  logic                cnt_last;
  logic                par_ok;
  logic                to_hit;

  // Shifting the pattern left by idx puts the expected header bit at the MSB.
  assign head_sh    = HEAD << idx_q;
  assign head_exp   = head_sh[HEAD_W-1];
  assign head_first = (i_bit_data == HEAD[HEAD_W-1]);
  assign idx_last   = (idx_q == IDX_W'(HEAD_W - 1));
  assign cnt_last   = (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign par_ok     = (i_bit_data == ^shift_q);
  // A strobe landing on the threshold cycle wins over the timeout.
  assign to_hit     = (state_q != S_IDLE) && (to_cnt_q == TO_TH) && !i_bit_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      to_cnt_q   <= '0;
      frm_data_q <= '0;
      frm_vld_q  <= 1'b0;
      par_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      to_cnt_q   <= to_cnt_d;
      frm_data_q <= frm_data_d;
      frm_vld_q  <= frm_vld_d;
      par_err_q  <= par_err_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (to_hit) begin
      state_d = S_IDLE;
    end else if (i_bit_vld) begin
      case (state_q)
        S_IDLE: if (head_first) state_d = (HEAD_W == 1) ? S_DATA : S_HEAD;
        S_HEAD: begin
          if (i_bit_data == head_exp) begin
            if (idx_last) state_d = S_DATA;
          end else if (!head_first) begin
            state_d = S_IDLE;
          end
        end
        S_DATA: if (cnt_last) state_d = S_PAR;
        S_PAR:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_d      = idx_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frm_data_d = frm_data_q;
    frm_vld_d  = 1'b0;
    par_err_d  = 1'b0;
    timeout_d  = to_hit;
    to_cnt_d   = to_cnt_q;
    if (i_bit_vld || state_q == S_IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q < TO_TH) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    if (i_bit_vld) begin
      case (state_q)
        S_IDLE: begin
          if (head_first) begin
            idx_d     = (HEAD_W == 1) ? '0 : IDX_W'(1);
            bit_cnt_d = '0;
          end
        end
        S_HEAD: begin
          if (i_bit_data == head_exp) begin
            if (idx_last) begin
              idx_d     = '0;
              bit_cnt_d = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            idx_d = head_first ? IDX_W'(1) : '0;
          end
        end
        S_DATA: begin
          shift_d   = (shift_q << 1) | DATA_W'(i_bit_data);
          bit_cnt_d = cnt_last ? '0 : bit_cnt_q + CNT_W'(1);
        end
        S_PAR: begin
          if (par_ok) begin
            frm_vld_d  = 1'b1;
            frm_data_d = shift_q;
          end else begin
            par_err_d = 1'b1;
          end
        end
        default: idx_d = '0;
      endcase
    end
  end

  assign o_frm_vld  = frm_vld_q;
  assign o_frm_data = frm_data_q;
  assign o_par_err  = par_err_q;
  assign o_timeout  = timeout_q;
  assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_owt_rx_frame.sv
// tb/tb_owt_rx_frame.sv - directed scoreboard bench for owt_rx_frame
module tb_owt_rx_frame;

  localparam int KIND_FRM = 0;
  localparam int KIND_PAR = 1;
  localparam int KIND_TO  = 2;

  typedef struct {
    int          kind;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        bit_vld;
  logic        bit_data;
  logic        frm_vld;
  logic [15:0] frm_data;
  logic        par_err;
  logic        timeout;
  logic        busy;

  int          checks;
  int          errors;
  exp_t        sb[$];
  logic [15:0] last_good;

  owt_rx_frame #(
    .DATA_W(16),
    .HEAD_W(4),
    .HEAD  (4'b1010),
    .TO_W  (10),
    .TO_TH (10'd512)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_bit_vld (bit_vld),
    .i_bit_data(bit_data),
    .o_frm_vld (frm_vld),
    .o_frm_data(frm_data),
    .o_par_err (par_err),
    .o_timeout (timeout),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every pulse must match the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    if (frm_vld || par_err || timeout) begin
      exp_t e;
      int   kind;
      chk("pulse_onehot", 32'(($countones({frm_vld, par_err, timeout}) == 1)), 32'd1);
      chk("pulse_expected", 32'((sb.size() > 0)), 32'd1);
      if (sb.size() > 0) begin
        e    = sb.pop_front();
        kind = frm_vld ? KIND_FRM : (par_err ? KIND_PAR : KIND_TO);
        chk("pulse_kind", 32'(kind), 32'(e.kind));
        chk("pulse_data", 32'(frm_data), 32'(e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_vld  = 1'b1;
    bit_data = b;
    @(negedge clk);
    bit_vld  = 1'b0;
    bit_data = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic push_exp(input int kind, input logic [15:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [15:0] payload, input logic bad);
    if (bad) push_exp(KIND_PAR, last_good);
    else begin
      push_exp(KIND_FRM, payload);
      last_good = payload;
    end
    send_bits(32'b1010, 4);
    send_bits(32'(payload), 16);
    send_bit((^payload) ^ bad);
    chk("frame_latency", 32'(sb.size()), 32'd0);
    chk("frame_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_vld"}, 32'(frm_vld), 32'd0);
    chk({tag, "_data"}, 32'(frm_data), 32'd0);
    chk({tag, "_par"}, 32'(par_err), 32'd0);
    chk({tag, "_to"}, 32'(timeout), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_good = 16'h0000;
    rst_n     = 1'b0;
    bit_vld   = 1'b0;
    bit_data  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Good frame, then the same frame with inverted parity.
    send_frame(16'hA5C3, 1'b0);
    chk("good_data", 32'(frm_data), 32'h0000A5C3);
    send_frame(16'hA5C3, 1'b1);
    @(negedge clk);
    chk("par_hold", 32'(frm_data), 32'h0000A5C3);

    // Header resync: 1,0,1,1,0,1,0 aligns on the second 1.
    push_exp(KIND_FRM, 16'h0001);
    last_good = 16'h0001;
    send_bits(32'b1011010, 7);
    send_bits(32'h0001, 16);
    send_bit(1'b1);
    chk("resync_latency", 32'(sb.size()), 32'd0);
    chk("resync_data", 32'(frm_data), 32'h00000001);

    // Timeout after header plus 5 payload bits.
    send_bits(32'b1010, 4);
    send_bits(32'b10110, 5);
    push_exp(KIND_TO, last_good);
    repeat (512) @(negedge clk);
    chk("to_not_early", 32'(sb.size()), 32'd1);
    chk("to_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    chk("to_fired", 32'(sb.size()), 32'd0);
    chk("to_busy_after", 32'(busy), 32'd0);
    chk("to_data_hold", 32'(frm_data), 32'h00000001);
    send_frame(16'h3C5A, 1'b0);

    // Strobe on the exact threshold cycle suppresses the timeout.
    send_bits(32'b1010, 4);
    send_bits(32'(16'hBEEF >> 11), 5);
    repeat (511) @(negedge clk);
    chk("th_busy", 32'(busy), 32'd1);
    push_exp(KIND_FRM, 16'hBEEF);
    last_good = 16'hBEEF;
    send_bits(32'(16'hBEEF & 16'h07FF), 11);
    chk("th_still_busy", 32'(busy), 32'd1);
    send_bit(^last_good);
    chk("th_latency", 32'(sb.size()), 32'd0);
    chk("th_data", 32'(frm_data), 32'h0000BEEF);

    // Reset mid-frame discards it silently.
    send_bits(32'b1010, 4);
    send_bits(32'(16'h1234 >> 6), 10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst_async");
    repeat (2) @(negedge clk);
    check_idle_outputs("midrst_hold");
    rst_n     = 1'b1;
    last_good = 16'h0000;
    send_frame(16'h8001, 1'b0);

    // A few random frames with random parity faults.
    for (int i = 0; i < 6; i++) begin
      send_frame(16'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
